// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer and periodic auto-refresh scheduler.
// Borrows the command bus from the controller via ref_req/ref_gnt.
module sdram_init_refresh #(
  parameter int          T_POWERUP    = 5000,
  parameter int          T_RP         = 2,
  parameter int          T_RFC        = 4,
  parameter int          T_MRD        = 2,
  parameter int          N_INIT_REF   = 8,
  parameter int          REF_INTERVAL = 390,
  parameter logic [12:0] MODE_REG     = 13'h022
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ok,
  output logic        sd_cke,
  output logic [3:0]  sd_cmd,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_a,
  output logic        init_done,
  output logic        ref_req,
  input  logic        ref_gnt,
  output logic        own_bus
);

  localparam logic [3:0] C_INH = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  localparam int TM1 = (T_POWERUP > T_RP) ? T_POWERUP : T_RP;
  localparam int TM2 = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int CW = $clog2(TMAX + 1);
  localparam int RW = $clog2(N_INIT_REF + 1);
  localparam int IW = $clog2(REF_INTERVAL + 1);

  typedef enum logic [2:0] {
    S_WAIT_CLK,
    S_POWERUP,
    S_PRE,
    S_REF,
    S_MRS,
    S_IDLE,
    S_RPRE,
    S_RREF
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] wcnt, wcnt_d;
  logic [RW-1:0] rcnt, rcnt_d;
  logic [IW-1:0] timer, timer_d;
  logic [2:0]    pending, pending_d;
  logic          issue;
  logic          cke_d, done_d, req_d, own_d;
  logic [3:0]    cmd_d;
  logic [12:0]   a_d;
  logic          wrap, ref_done;

  assign wrap     = init_done && (timer == IW'(REF_INTERVAL - 1));
  assign ref_done = (state == S_RREF) && (wcnt == '0);
  assign sd_ba    = 2'b00;

  always_comb begin
    state_d   = state;
    wcnt_d    = wcnt;
    rcnt_d    = rcnt;
    issue     = 1'b0;
    timer_d   = '0;
    pending_d = pending;
    cke_d     = 1'b1;
    cmd_d     = C_NOP;
    a_d       = '0;

    // Each command state lasts T cycles: command in the first, NOP after.
    unique case (state)
      S_WAIT_CLK: begin
        if (clk_ok) begin
          state_d = S_POWERUP;
          wcnt_d  = CW'(T_POWERUP - 1);
        end
      end
      S_POWERUP: begin
        if (wcnt == '0) begin
          state_d = S_PRE;
          issue   = 1'b1;
          wcnt_d  = CW'(T_RP - 1);
        end else begin
          wcnt_d = wcnt - CW'(1);
        end
      end
      S_PRE: begin
        if (wcnt == '0) begin
          state_d = S_REF;
          issue   = 1'b1;
          wcnt_d  = CW'(T_RFC - 1);
          rcnt_d  = '0;
        end else begin
          wcnt_d = wcnt - CW'(1);
        end
      end
      S_REF: begin
        if (wcnt != '0) begin
          wcnt_d = wcnt - CW'(1);
        end else if (rcnt == RW'(N_INIT_REF - 1)) begin
          state_d = S_MRS;
          issue   = 1'b1;
          wcnt_d  = CW'(T_MRD - 1);
        end else begin
          issue  = 1'b1;
          rcnt_d = rcnt + RW'(1);
          wcnt_d = CW'(T_RFC - 1);
        end
      end
      S_MRS: begin
        if (wcnt == '0) state_d = S_IDLE;
        else wcnt_d = wcnt - CW'(1);
      end
      S_IDLE: begin
        if (ref_req && ref_gnt) begin
          state_d = S_RPRE;
          issue   = 1'b1;
          wcnt_d  = CW'(T_RP - 1);
        end
      end
      S_RPRE: begin
        if (wcnt == '0) begin
          state_d = S_RREF;
          issue   = 1'b1;
          wcnt_d  = CW'(T_RFC - 1);
        end else begin
          wcnt_d = wcnt - CW'(1);
        end
      end
      S_RREF: begin
        if (wcnt == '0) state_d = S_IDLE;
        else wcnt_d = wcnt - CW'(1);
      end
    endcase

    if (init_done && !wrap) timer_d = timer + IW'(1);

    if (wrap && !ref_done && pending != 3'd7) pending_d = pending + 3'd1;
    else if (!wrap && ref_done && pending != 3'd0) pending_d = pending - 3'd1;

    if (!clk_ok) begin
      state_d   = S_WAIT_CLK;
      wcnt_d    = '0;
      rcnt_d    = '0;
      issue     = 1'b0;
      timer_d   = '0;
      pending_d = '0;
    end

    own_d  = (state_d != S_IDLE);
    done_d = (state_d == S_IDLE) || (state_d == S_RPRE) ||
             (state_d == S_RREF);
    req_d  = done_d && (pending_d != 3'd0);

    if (state_d == S_WAIT_CLK) begin
      cke_d = 1'b0;
      cmd_d = C_INH;
    end else if (issue) begin
      unique case (state_d)
        S_PRE, S_RPRE: begin
          cmd_d   = C_PRE;
          a_d[10] = 1'b1;
        end
        S_REF, S_RREF: cmd_d = C_REF;
        S_MRS: begin
          cmd_d = C_LMR;
          a_d   = MODE_REG;
        end
        default: cmd_d = C_NOP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_WAIT_CLK;
      wcnt      <= '0;
      rcnt      <= '0;
      timer     <= '0;
      pending   <= '0;
      sd_cke    <= 1'b0;
      sd_cmd    <= C_INH;
      sd_a      <= '0;
      init_done <= 1'b0;
      ref_req   <= 1'b0;
      own_bus   <= 1'b1;
    end else begin
      state     <= state_d;
      wcnt      <= wcnt_d;
      rcnt      <= rcnt_d;
      timer     <= timer_d;
      pending   <= pending_d;
      sd_cke    <= cke_d;
      sd_cmd    <= cmd_d;
      sd_a      <= a_d;
      init_done <= done_d;
      ref_req   <= req_d;
      own_bus   <= own_d;
    end
  end

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh with an expected-value queue.
// Expected cycles and commands are derived from the default parameters.
module tb_sdram_init_refresh;

  localparam logic [3:0] C_INH = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam int TPU = 5000;
  localparam int TRP = 2;
  localparam int TRFC = 4;
  localparam int NREF = 8;
  localparam int RINT = 390;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_ok;
  logic        ref_gnt;
  logic        sd_cke;
  logic [3:0]  sd_cmd;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic        init_done;
  logic        ref_req;
  logic        own_bus;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  string tagq[$];
  logic [31:0] expq[$];

  sdram_init_refresh dut (
    .clk(clk),
    .reset(reset),
    .clk_ok(clk_ok),
    .sd_cke(sd_cke),
    .sd_cmd(sd_cmd),
    .sd_ba(sd_ba),
    .sd_a(sd_a),
    .init_done(init_done),
    .ref_req(ref_req),
    .ref_gnt(ref_gnt),
    .own_bus(own_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] e);
    tagq.push_back(t);
    expq.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    t = tagq.pop_front();
    e = expq.pop_front();
    compared++;
    assert (obs === e)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, e);
    end
  endtask

  task automatic check(input string t, input logic [31:0] obs,
                       input logic [31:0] e);
    push(t, e);
    pop_check(obs);
  endtask

  task automatic next_cmd(output int at, output logic [3:0] c);
    at = -1;
    c  = 4'hx;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (sd_cmd !== C_NOP) begin
        at = cyc;
        c  = sd_cmd;
        return;
      end
    end
  endtask

  task automatic wait_req(input logic v, output int at);
    at = -1;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (ref_req === v) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic expect_cmd(input string t, input logic [3:0] ce,
                            input int at_e, output int at);
    logic [3:0] c;
    push({t, " cyc"}, at_e);
    push({t, " cmd"}, 32'(ce));
    next_cmd(at, c);
    pop_check(at);
    pop_check(32'(c));
  endtask

  task automatic init_cmds(input int pre_at);
    int at;
    expect_cmd("pre", C_PRE, pre_at, at);
    check("pre a10", 32'(sd_a[10]), 1);
    for (int i = 0; i < NREF; i++)
      expect_cmd($sformatf("iref%0d", i), C_REF,
                 pre_at + TRP + i * TRFC, at);
    expect_cmd("mrs", C_LMR, pre_at + TRP + NREF * TRFC, at);
    check("mrs a", 32'(sd_a), 32'h022);
    check("mrs ba", 32'(sd_ba), 0);
  endtask

  task automatic init_done_chk();
    step();
    check("done early", 32'(init_done), 0);
    step();
    check("init_done", 32'(init_done), 1);
    check("own idle", 32'(own_bus), 0);
    check("cmd idle", 32'(sd_cmd), 32'(C_NOP));
  endtask

  task automatic refresh_round(input string t, input int req_at);
    int at;
    wait_req(1'b1, at);
    check({t, " req"}, at, req_at);
    expect_cmd({t, " pre"}, C_PRE, req_at + 1, at);
    check({t, " a10"}, 32'(sd_a[10]), 1);
    check({t, " own"}, 32'(own_bus), 1);
    expect_cmd({t, " ref"}, C_REF, req_at + 3, at);
    wait_req(1'b0, at);
    check({t, " req low"}, at, req_at + 7);
    check({t, " own low"}, 32'(own_bus), 0);
  endtask

  initial begin
    int idle_at;
    int at;
    int g;
    int s;
    int r;

    reset   = 1'b1;
    clk_ok  = 1'b0;
    ref_gnt = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (1000) step();
    check("rst cke", 32'(sd_cke), 0);
    check("rst cmd", 32'(sd_cmd), 32'(C_INH));
    check("rst done", 32'(init_done), 0);
    check("rst own", 32'(own_bus), 1);
    check("rst req", 32'(ref_req), 0);
    check("rst a", 32'(sd_a), 0);

    clk_ok = 1'b1;
    s = cyc;
    step();
    check("pwrup cke", 32'(sd_cke), 1);
    check("pwrup cmd", 32'(sd_cmd), 32'(C_NOP));
    init_cmds(s + 1 + TPU);
    init_done_chk();
    idle_at = s + 1 + TPU + TRP + NREF * TRFC + 2;

    ref_gnt = 1'b1;
    refresh_round("r1", idle_at + RINT);
    refresh_round("r2", idle_at + 2 * RINT);
    ref_gnt = 1'b0;

    while (cyc < idle_at + 12 * RINT + 5) step();
    check("sat req", 32'(ref_req), 1);
    ref_gnt = 1'b1;
    g = cyc;
    for (int n = 0; n < 7; n++) begin
      expect_cmd($sformatf("bb%0d pre", n), C_PRE, g + 1 + 7 * n, at);
      expect_cmd($sformatf("bb%0d ref", n), C_REF, g + 3 + 7 * n, at);
    end
    wait_req(1'b0, at);
    check("bb req low", at, g + 49);
    ref_gnt = 1'b0;

    clk_ok = 1'b0;
    step();
    check("drop cke", 32'(sd_cke), 0);
    check("drop cmd", 32'(sd_cmd), 32'(C_INH));
    check("drop done", 32'(init_done), 0);
    check("drop own", 32'(own_bus), 1);
    clk_ok = 1'b1;
    s = cyc;
    expect_cmd("re pre", C_PRE, s + 1 + TPU, at);
    expect_cmd("re iref0", C_REF, s + 1 + TPU + TRP, r);
    step();
    clk_ok = 1'b0;
    step();
    check("refw cke", 32'(sd_cke), 0);
    check("refw cmd", 32'(sd_cmd), 32'(C_INH));
    clk_ok = 1'b1;
    s = cyc;
    step();
    check("replay cke", 32'(sd_cke), 1);
    init_cmds(s + 1 + TPU);
    init_done_chk();
    idle_at = s + 1 + TPU + TRP + NREF * TRFC + 2;

    ref_gnt = 1'b1;
    wait_req(1'b1, at);
    check("rr req", at, idle_at + RINT);
    expect_cmd("rr pre", C_PRE, idle_at + RINT + 1, at);
    expect_cmd("rr ref", C_REF, idle_at + RINT + 3, at);
    step();
    clk_ok = 1'b0;
    step();
    check("rrw cke", 32'(sd_cke), 0);
    check("rrw cmd", 32'(sd_cmd), 32'(C_INH));
    check("rrw req", 32'(ref_req), 0);
    check("rrw done", 32'(init_done), 0);
    check("rrw own", 32'(own_bus), 1);
    ref_gnt = 1'b0;
    clk_ok = 1'b1;
    s = cyc;
    init_cmds(s + 1 + TPU);

    step();
    #3;
    reset = 1'b1;
    #1;
    check("async cke", 32'(sd_cke), 0);
    check("async cmd", 32'(sd_cmd), 32'(C_INH));
    check("async a", 32'(sd_a), 0);
    check("async done", 32'(init_done), 0);
    check("async own", 32'(own_bus), 1);
    check("async req", 32'(ref_req), 0);
    clk_ok = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("post rst cmd", 32'(sd_cmd), 32'(C_INH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
